// File: rtl/rv_instr_encoder_if.sv
// Field-bundle input and instruction-memory write port of the RV32I encoder.
// The host/memory side uses master; the encoder uses slave.
interface rv_instr_encoder_if #(
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 256
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              clear;
  logic              in_valid;
  logic              in_ready;
  logic [3:0]        op_class;
  logic [2:0]        funct3;
  logic              funct7b;
  logic [4:0]        rd;
  logic [4:0]        rs1;
  logic [4:0]        rs2;
  logic [31:0]       imm;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [31:0]       wr_data;
  logic [CW-1:0]     count;
  logic              full;
  logic              err;
  logic [2:0]        err_code;

  modport master (
    output clear, in_valid, op_class, funct3, funct7b, rd, rs1, rs2, imm, wr_ready,
    input  in_ready, wr_valid, wr_addr, wr_data, count, full, err, err_code
  );

  modport slave (
    input  clear, in_valid, op_class, funct3, funct7b, rd, rs1, rs2, imm, wr_ready,
    output in_ready, wr_valid, wr_addr, wr_data, count, full, err, err_code
  );
endinterface

// File: rtl/rv_instr_encoder.sv
// Packs RV32I fields into instruction words and streams them to instruction memory
// through a one-deep stallable output register; illegal bundles raise a sticky error.
module rv_instr_encoder #(
  parameter int DEPTH  = 256,
  parameter int ADDR_W = 32
) (
  input  logic                clk,
  input  logic                rst,
  rv_instr_encoder_if.slave   bus
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic              wr_valid_reg;
  logic [ADDR_W-1:0] wr_addr_reg;
  logic [31:0]       wr_data_reg;
  logic [CW-1:0]     count_reg;
  logic              full_reg;
  logic              err_reg;
  logic [2:0]        err_code_reg;

  logic [31:0] imm;
  logic [3:0]  cls;
  logic [2:0]  f3;
  logic [31:0] enc;
  logic [2:0]  code;
  logic        is_shift;
  logic        fits12, fits13, fits21;
  logic        accept, fire, legal;

  assign imm = bus.imm;
  assign cls = bus.op_class;
  assign f3  = bus.funct3;

  // Signed range holds when every bit above the sign bit equals the sign bit.
  assign fits12   = (&imm[31:11]) | ~(|imm[31:11]);
  assign fits13   = (&imm[31:12]) | ~(|imm[31:12]);
  assign fits21   = (&imm[31:20]) | ~(|imm[31:20]);
  assign is_shift = (cls == 4'd1) && ((f3 == 3'd1) || (f3 == 3'd5));

  always_comb begin
    enc = '0;
    case (cls)
      4'd0: enc = {1'b0, bus.funct7b, 5'b0, bus.rs2, bus.rs1, f3, bus.rd, 7'd51};
      4'd1: enc = is_shift ? {1'b0, bus.funct7b, 5'b0, imm[4:0], bus.rs1, f3, bus.rd, 7'd19}
                           : {imm[11:0], bus.rs1, f3, bus.rd, 7'd19};
      4'd2: enc = {imm[11:0], bus.rs1, f3, bus.rd, 7'd3};
      4'd3: enc = {imm[11:5], bus.rs2, bus.rs1, f3, imm[4:0], 7'd35};
      4'd4: enc = {imm[12], imm[10:5], bus.rs2, bus.rs1, f3, imm[4:1], imm[11], 7'd99};
      4'd5: enc = {imm[31:12], bus.rd, 7'd55};
      4'd6: enc = {imm[31:12], bus.rd, 7'd23};
      4'd7: enc = {imm[11:0], bus.rs1, 3'd0, bus.rd, 7'd103};
      4'd8: enc = {imm[20], imm[10:1], imm[11], imm[19:12], bus.rd, 7'd111};
      default: enc = '0;
    endcase
  end

  // First matching check wins, so the reported code reflects the highest-priority fault.
  always_comb begin
    code = 3'd0;
    if (cls > 4'd8)
      code = 3'd1;
    else if ((((cls == 4'd1) || (cls == 4'd2) || (cls == 4'd3) || (cls == 4'd7)) && !fits12) ||
             ((cls == 4'd4) && !fits13) || ((cls == 4'd8) && !fits21))
      code = 3'd2;
    else if ((((cls == 4'd4) || (cls == 4'd8)) && imm[0]) ||
             (((cls == 4'd5) || (cls == 4'd6)) && (imm[11:0] != 12'd0)))
      code = 3'd3;
    else if (((cls == 4'd4) && ((f3 == 3'd2) || (f3 == 3'd3))) ||
             ((cls == 4'd2) && ((f3 == 3'd3) || (f3 >= 3'd6))) ||
             ((cls == 4'd3) && (f3 > 3'd2)))
      code = 3'd4;
    else if ((is_shift && (imm[11:5] != 7'd0)) ||
             ((cls == 4'd0) && bus.funct7b && (f3 != 3'd0) && (f3 != 3'd5)))
      code = 3'd5;
  end

  assign legal        = (code == 3'd0);
  assign bus.in_ready = !full_reg && (!wr_valid_reg || bus.wr_ready);
  assign accept       = bus.in_valid && bus.in_ready;
  assign fire         = wr_valid_reg && bus.wr_ready;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      wr_data_reg  <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 3'd0;
    end else if (bus.clear) begin
      wr_valid_reg <= 1'b0;
      wr_addr_reg  <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      err_reg      <= 1'b0;
      err_code_reg <= 3'd0;
    end else begin
      if (fire) begin
        count_reg <= count_reg + 1'b1;
        if (count_reg == CW'(DEPTH - 1)) begin
          full_reg    <= 1'b1;
          wr_addr_reg <= '0;
        end else begin
          wr_addr_reg <= wr_addr_reg + ADDR_W'(4);
        end
      end
      if (accept && legal) begin
        wr_valid_reg <= 1'b1;
        wr_data_reg  <= enc;
      end else if (fire) begin
        wr_valid_reg <= 1'b0;
      end
      if (accept && !legal && !err_reg) begin
        err_reg      <= 1'b1;
        err_code_reg <= code;
      end
    end
  end

  assign bus.wr_valid = wr_valid_reg;
  assign bus.wr_addr  = wr_addr_reg;
  assign bus.wr_data  = wr_data_reg;
  assign bus.count    = count_reg;
  assign bus.full     = full_reg;
  assign bus.err      = err_reg;
  assign bus.err_code = err_code_reg;
endmodule

// File: tb/tb_rv_instr_encoder.sv
// Directed bench for rv_instr_encoder: encodings, stalls, errors, full/wrap and reset.
module tb_rv_instr_encoder;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  rv_instr_encoder_if #(.ADDR_W(32), .DEPTH(256)) bus ();
  rv_instr_encoder_if #(.ADDR_W(32), .DEPTH(4))   b4 ();

  rv_instr_encoder #(.DEPTH(256), .ADDR_W(32)) dut  (.clk(clk), .rst(rst), .bus(bus));
  rv_instr_encoder #(.DEPTH(4),   .ADDR_W(32)) dut4 (.clk(clk), .rst(rst), .bus(b4));

  typedef struct {
    logic [3:0]  c;
    logic [2:0]  f3;
    logic        f7;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [31:0] imm;
    logic [31:0] exp;
  } vec_t;

  typedef struct {
    logic [3:0]  c;
    logic [2:0]  f3;
    logic        f7;
    logic [31:0] imm;
    logic [2:0]  code;
  } errv_t;

  always @(posedge clk) begin
    if (!rst && bus.wr_valid && bus.wr_ready)
      $display("write dut  addr=%h data=%h", bus.wr_addr, bus.wr_data);
    if (!rst && b4.wr_valid && b4.wr_ready)
      $display("write dut4 addr=%h data=%h", b4.wr_addr, b4.wr_data);
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic [3:0] c, input logic [2:0] f3, input logic f7,
                       input logic [4:0] rd, input logic [4:0] rs1, input logic [4:0] rs2,
                       input logic [31:0] imm);
    bus.op_class = c;
    bus.funct3   = f3;
    bus.funct7b  = f7;
    bus.rd       = rd;
    bus.rs1      = rs1;
    bus.rs2      = rs2;
    bus.imm      = imm;
    bus.in_valid = 1'b1;
  endtask

  task automatic idle();
    bus.in_valid = 1'b0;
  endtask

  task automatic do_clear();
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
  endtask

  task automatic test_reset();
    bus.clear = 0; bus.in_valid = 0; bus.wr_ready = 1;
    bus.op_class = 0; bus.funct3 = 0; bus.funct7b = 0;
    bus.rd = 0; bus.rs1 = 0; bus.rs2 = 0; bus.imm = 0;
    b4.clear = 0; b4.in_valid = 0; b4.wr_ready = 1;
    b4.op_class = 4'd1; b4.funct3 = 0; b4.funct7b = 0;
    b4.rd = 5'd1; b4.rs1 = 0; b4.rs2 = 0; b4.imm = 32'd5;
    rst = 1'b1;
    step(); step();
    rst = 1'b0;
    step();
    checks++; if (bus.wr_valid !== 1'b0) begin errors++; $display("FAIL reset_wr_valid got %b want 0", bus.wr_valid); end
    checks++; if (bus.wr_addr !== 32'd0) begin errors++; $display("FAIL reset_wr_addr got %h want 0", bus.wr_addr); end
    checks++; if (bus.wr_data !== 32'd0) begin errors++; $display("FAIL reset_wr_data got %h want 0", bus.wr_data); end
    checks++; if (bus.count !== 9'd0) begin errors++; $display("FAIL reset_count got %0d want 0", bus.count); end
    checks++; if (bus.full !== 1'b0) begin errors++; $display("FAIL reset_full got %b want 0", bus.full); end
    checks++; if (bus.err !== 1'b0 || bus.err_code !== 3'd0) begin errors++; $display("FAIL reset_err got %b/%0d want 0/0", bus.err, bus.err_code); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %b want 1", bus.in_ready); end
  endtask

  task automatic test_addi();
    drive(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    step();
    idle();
    checks++; if (bus.wr_valid !== 1'b1) begin errors++; $display("FAIL addi_valid got %b want 1", bus.wr_valid); end
    checks++; if (bus.wr_data !== 32'h00500093) begin errors++; $display("FAIL addi_data got %h want 00500093", bus.wr_data); end
    checks++; if (bus.wr_addr !== 32'd0) begin errors++; $display("FAIL addi_addr got %h want 0", bus.wr_addr); end
    step();
    checks++; if (bus.count !== 9'd1 || bus.wr_valid !== 1'b0) begin errors++; $display("FAIL addi_done count %0d valid %b want 1/0", bus.count, bus.wr_valid); end
    checks++; if (bus.wr_addr !== 32'd4) begin errors++; $display("FAIL addi_next_addr got %h want 4", bus.wr_addr); end
  endtask

  task automatic test_back_to_back();
    do_clear();
    bus.wr_ready = 1'b1;
    drive(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    checks++; if (bus.wr_data !== 32'h002081B3 || bus.wr_addr !== 32'd0) begin errors++; $display("FAIL b2b_add got %h@%h want 002081b3@0", bus.wr_data, bus.wr_addr); end
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL b2b_in_ready got %b want 1", bus.in_ready); end
    drive(4'd0, 3'd0, 1'b1, 5'd3, 5'd1, 5'd2, 32'd0);
    step();
    idle();
    checks++; if (bus.wr_data !== 32'h402081B3 || bus.wr_addr !== 32'd4) begin errors++; $display("FAIL b2b_sub got %h@%h want 402081b3@4", bus.wr_data, bus.wr_addr); end
    checks++; if (bus.count !== 9'd1 || bus.wr_valid !== 1'b1) begin errors++; $display("FAIL b2b_mid count %0d valid %b want 1/1", bus.count, bus.wr_valid); end
    step();
    checks++; if (bus.count !== 9'd2 || bus.wr_valid !== 1'b0) begin errors++; $display("FAIL b2b_end count %0d valid %b want 2/0", bus.count, bus.wr_valid); end
  endtask

  task automatic test_encodings();
    vec_t v[10];
    v[0] = '{4'd3, 3'd2, 1'b0, 5'd0, 5'd1, 5'd2, 32'd4,          32'h0020A223};
    v[1] = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd8,          32'h00208463};
    v[2] = '{4'd8, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd16,         32'h010000EF};
    v[3] = '{4'd5, 3'd0, 1'b0, 5'd5, 5'd0, 5'd0, 32'h12345000,   32'h123452B7};
    v[4] = '{4'd1, 3'd5, 1'b1, 5'd1, 5'd2, 5'd0, 32'd3,          32'h40315093};
    v[5] = '{4'd7, 3'd3, 1'b0, 5'd1, 5'd5, 5'd0, 32'd0,          32'h000280E7};
    v[6] = '{4'd6, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'h00001000,   32'h00001097};
    v[7] = '{4'd2, 3'd2, 1'b0, 5'd1, 5'd2, 5'd0, 32'hFFFFFFFC,   32'hFFC12083};
    v[8] = '{4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'hFFFFF800,   32'h80000093};
    v[9] = '{4'd4, 3'd0, 1'b0, 5'd0, 5'd0, 5'd0, 32'hFFFFF000,   32'h80000063};
    do_clear();
    bus.wr_ready = 1'b1;
    for (int i = 0; i < 10; i++) begin
      drive(v[i].c, v[i].f3, v[i].f7, v[i].rd, v[i].rs1, v[i].rs2, v[i].imm);
      step();
      idle();
      checks++;
      if (bus.wr_valid !== 1'b1 || bus.wr_data !== v[i].exp || bus.wr_addr !== 32'(4 * i)) begin
        errors++;
        $display("FAIL enc_%0d got %b %h@%h want 1 %h@%h", i, bus.wr_valid, bus.wr_data, bus.wr_addr, v[i].exp, 32'(4 * i));
      end
      step();
    end
    checks++; if (bus.count !== 9'd10) begin errors++; $display("FAIL enc_count got %0d want 10", bus.count); end
  endtask

  task automatic test_stall();
    do_clear();
    bus.wr_ready = 1'b0;
    drive(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    step();
    drive(4'd0, 3'd0, 1'b0, 5'd3, 5'd1, 5'd2, 32'd0);
    for (int i = 0; i < 3; i++) begin
      checks++;
      if (bus.wr_data !== 32'h00500093 || bus.wr_addr !== 32'd0 || bus.in_ready !== 1'b0 || bus.count !== 9'd0) begin
        errors++;
        $display("FAIL stall_hold_%0d got %h@%h rdy %b cnt %0d want 00500093@0 rdy 0 cnt 0", i, bus.wr_data, bus.wr_addr, bus.in_ready, bus.count);
      end
      step();
    end
    bus.wr_ready = 1'b1;
    #1;
    checks++; if (bus.in_ready !== 1'b1) begin errors++; $display("FAIL stall_release_ready got %b want 1", bus.in_ready); end
    step();
    idle();
    checks++; if (bus.wr_data !== 32'h002081B3 || bus.wr_addr !== 32'd4 || bus.count !== 9'd1) begin errors++; $display("FAIL stall_second got %h@%h cnt %0d want 002081b3@4 cnt 1", bus.wr_data, bus.wr_addr, bus.count); end
    step();
    checks++; if (bus.count !== 9'd2 || bus.wr_valid !== 1'b0) begin errors++; $display("FAIL stall_end count %0d valid %b want 2/0", bus.count, bus.wr_valid); end
  endtask

  task automatic test_errors();
    errv_t e[11];
    e[0]  = '{4'd9, 3'd0, 1'b0, 32'd0,        3'd1};
    e[1]  = '{4'd1, 3'd0, 1'b0, 32'd4096,     3'd2};
    e[2]  = '{4'd4, 3'd0, 1'b0, 32'd4096,     3'd2};
    e[3]  = '{4'd8, 3'd0, 1'b0, 32'h00100000, 3'd2};
    e[4]  = '{4'd5, 3'd0, 1'b0, 32'h12345001, 3'd3};
    e[5]  = '{4'd4, 3'd2, 1'b0, 32'd3,        3'd3};
    e[6]  = '{4'd2, 3'd3, 1'b0, 32'd0,        3'd4};
    e[7]  = '{4'd3, 3'd3, 1'b0, 32'd0,        3'd4};
    e[8]  = '{4'd4, 3'd2, 1'b0, 32'd8,        3'd4};
    e[9]  = '{4'd1, 3'd1, 1'b0, 32'd32,       3'd5};
    e[10] = '{4'd0, 3'd1, 1'b1, 32'd0,        3'd5};
    do_clear();
    bus.wr_ready = 1'b1;
    drive(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    step(); idle(); step();
    drive(4'd4, 3'd0, 1'b0, 5'd0, 5'd1, 5'd2, 32'd3);
    step();
    idle();
    checks++; if (bus.err !== 1'b1 || bus.err_code !== 3'd3) begin errors++; $display("FAIL err_beq got %b/%0d want 1/3", bus.err, bus.err_code); end
    checks++; if (bus.wr_valid !== 1'b0 || bus.count !== 9'd1) begin errors++; $display("FAIL err_beq_drop valid %b cnt %0d want 0/1", bus.wr_valid, bus.count); end
    drive(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd4096);
    step();
    idle();
    checks++; if (bus.err_code !== 3'd3 || bus.wr_valid !== 1'b0) begin errors++; $display("FAIL err_sticky code %0d valid %b want 3/0", bus.err_code, bus.wr_valid); end
    do_clear();
    checks++; if (bus.err !== 1'b0 || bus.err_code !== 3'd0 || bus.count !== 9'd0) begin errors++; $display("FAIL err_clear got %b/%0d cnt %0d want 0/0/0", bus.err, bus.err_code, bus.count); end
    for (int i = 0; i < 11; i++) begin
      do_clear();
      drive(e[i].c, e[i].f3, e[i].f7, 5'd1, 5'd1, 5'd2, e[i].imm);
      step();
      idle();
      checks++;
      if (bus.err !== 1'b1 || bus.err_code !== e[i].code || bus.wr_valid !== 1'b0) begin
        errors++;
        $display("FAIL err_case_%0d got err %b code %0d valid %b want 1 %0d 0", i, bus.err, bus.err_code, bus.wr_valid, e[i].code);
      end
    end
  endtask

  task automatic test_clear_priority();
    do_clear();
    drive(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    bus.clear = 1'b1;
    step();
    bus.clear = 1'b0;
    idle();
    checks++; if (bus.wr_valid !== 1'b0 || bus.count !== 9'd0) begin errors++; $display("FAIL clear_prio valid %b cnt %0d want 0/0", bus.wr_valid, bus.count); end
  endtask

  task automatic test_full();
    b4.clear = 1'b1; step(); b4.clear = 1'b0;
    b4.wr_ready = 1'b1;
    b4.in_valid = 1'b1;
    step(); step(); step(); step();
    b4.in_valid = 1'b0;
    checks++; if (b4.wr_addr !== 32'd12 || b4.count !== 3'd3) begin errors++; $display("FAIL full_pre addr %h cnt %0d want c/3", b4.wr_addr, b4.count); end
    step();
    checks++; if (b4.full !== 1'b1 || b4.count !== 3'd4) begin errors++; $display("FAIL full_flag full %b cnt %0d want 1/4", b4.full, b4.count); end
    checks++; if (b4.wr_addr !== 32'd0 || b4.in_ready !== 1'b0) begin errors++; $display("FAIL full_wrap addr %h rdy %b want 0/0", b4.wr_addr, b4.in_ready); end
    b4.in_valid = 1'b1;
    step();
    b4.in_valid = 1'b0;
    checks++; if (b4.wr_valid !== 1'b0 || b4.count !== 3'd4 || b4.full !== 1'b1) begin errors++; $display("FAIL full_block valid %b cnt %0d full %b want 0/4/1", b4.wr_valid, b4.count, b4.full); end
    b4.clear = 1'b1; step(); b4.clear = 1'b0;
    checks++; if (b4.count !== 3'd0 || b4.full !== 1'b0 || b4.in_ready !== 1'b1) begin errors++; $display("FAIL full_clear cnt %0d full %b rdy %b want 0/0/1", b4.count, b4.full, b4.in_ready); end
  endtask

  task automatic test_rst_stall();
    do_clear();
    bus.wr_ready = 1'b0;
    drive(4'd1, 3'd0, 1'b0, 5'd1, 5'd0, 5'd0, 32'd5);
    step();
    idle();
    checks++; if (bus.wr_valid !== 1'b1) begin errors++; $display("FAIL rst_stall_pending got %b want 1", bus.wr_valid); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (bus.wr_valid !== 1'b0 || bus.wr_data !== 32'd0) begin errors++; $display("FAIL rst_async valid %b data %h want 0/0", bus.wr_valid, bus.wr_data); end
    step();
    rst = 1'b0;
    bus.wr_ready = 1'b1;
    step();
    checks++; if (bus.wr_valid !== 1'b0 || bus.count !== 9'd0) begin errors++; $display("FAIL rst_after valid %b cnt %0d want 0/0", bus.wr_valid, bus.count); end
  endtask

  initial begin
    test_reset();
    test_addi();
    test_back_to_back();
    test_encodings();
    test_stall();
    test_errors();
    test_clear_priority();
    test_full();
    test_rst_stall();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
